// File: rtl/renkon_pkg.sv
// Shared renkon datapath constants: pixel/bias width, signed data type and saturation limits.
package renkon_pkg;

    localparam int DWIDTH = 16;

    typedef logic signed [DWIDTH-1:0] data_t;

    localparam data_t DATA_MAX = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam data_t DATA_MIN = {1'b1, {(DWIDTH-1){1'b0}}};

endpackage

// File: rtl/renkon_sat_add.sv
// Combinational signed adder that clamps the result to the data_t range instead of wrapping.
module renkon_sat_add
    import renkon_pkg::*;
(
    input  data_t a_i,
    input  data_t b_i,
    output data_t sum_o
);

    logic signed [DWIDTH:0] wide_sum;

    assign wide_sum = {a_i[DWIDTH-1], a_i} + {b_i[DWIDTH-1], b_i};

    // The top two bits of the widened sum disagree exactly when the result leaves the DWIDTH range.
    always_comb begin
        sum_o = wide_sum[DWIDTH-1:0];
        if (wide_sum[DWIDTH] != wide_sum[DWIDTH-1]) begin
            sum_o = wide_sum[DWIDTH] ? DATA_MIN : DATA_MAX;
        end
    end

endmodule

// File: rtl/renkon_bias.sv
// Bias stage: latches a per-channel bias and adds it (saturating) to each enabled pixel.
// Output is registered with one cycle of latency; there is no backpressure.
module renkon_bias
    import renkon_pkg::*;
(
    input  logic  clk,
    input  logic  xrst,
    input  logic  breg_we,
    input  logic  out_en,
    input  data_t read_bias,
    input  data_t pixel_in,
    output data_t pixel_out
);

    data_t bias_q, bias_d;
    data_t pix_q, pix_d;
    data_t biased;

    renkon_sat_add u_sat_add (
        .a_i   (pixel_in),
        .b_i   (bias_q),
        .sum_o (biased)
    );

    // The adder reads bias_q, so a bias captured this edge only affects the next pixel.
    always_comb begin
        bias_d = bias_q;
        pix_d  = '0;
        if (breg_we) begin
            bias_d = read_bias;
        end
        if (out_en) begin
            pix_d = biased;
        end
    end

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            bias_q <= '0;
            pix_q  <= '0;
        end else begin
            bias_q <= bias_d;
            pix_q  <= pix_d;
        end
    end

    assign pixel_out = pix_q;

endmodule

// File: tb/tb_renkon_bias.sv
// Directed bench for renkon_bias: reset, streaming, bias collision, saturation and async reset.
module tb_renkon_bias;
    import renkon_pkg::*;

    logic  clk = 1'b0;
    logic  xrst;
    logic  breg_we;
    logic  out_en;
    data_t read_bias;
    data_t pixel_in;
    data_t pixel_out;

    int n_cmp = 0;
    int n_bad = 0;

    renkon_bias dut (
        .clk       (clk),
        .xrst      (xrst),
        .breg_we   (breg_we),
        .out_en    (out_en),
        .read_bias (read_bias),
        .pixel_in  (pixel_in),
        .pixel_out (pixel_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bias(input data_t b);
        read_bias = b;
        breg_we   = 1'b1;
        out_en    = 1'b0;
        tick();
        breg_we   = 1'b0;
    endtask

    task automatic test_reset();
        data_t exp;
        xrst      = 1'b1;
        breg_we   = 1'b0;
        read_bias = 16'sd10;
        pixel_in  = 16'sd5;
        out_en    = 1'b1;
        exp       = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (pixel_out !== exp) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: got %0d expected %0d", i, pixel_out, exp);
            end
        end
        xrst = 1'b0;
        tick();
        exp = 16'sd5;
        n_cmp++;
        if (pixel_out !== exp) begin
            n_bad++;
            $display("FAIL reset_release: got %0d expected %0d", pixel_out, exp);
        end
    endtask

    task automatic test_load_stream();
        data_t exp;
        load_bias(16'sd10);
        for (int i = 0; i < 30; i++) begin
            pixel_in = data_t'(i);
            out_en   = (i >= 10 && i <= 19);
            tick();
            exp = (i >= 10 && i <= 19) ? data_t'(i + 10) : data_t'(0);
            n_cmp++;
            if (pixel_out !== exp) begin
                n_bad++;
                $display("FAIL stream[%0d]: got %0d expected %0d", i, pixel_out, exp);
            end
        end
        out_en = 1'b0;
    endtask

    task automatic test_collision();
        data_t exp;
        read_bias = -16'sd3;
        breg_we   = 1'b1;
        out_en    = 1'b1;
        pixel_in  = 16'sd7;
        tick();
        exp = 16'sd17;
        n_cmp++;
        if (pixel_out !== exp) begin
            n_bad++;
            $display("FAIL collision_old_bias: got %0d expected %0d", pixel_out, exp);
        end
        breg_we = 1'b0;
        tick();
        exp = 16'sd4;
        n_cmp++;
        if (pixel_out !== exp) begin
            n_bad++;
            $display("FAIL collision_new_bias: got %0d expected %0d", pixel_out, exp);
        end
        out_en = 1'b0;
    endtask

    task automatic test_pos_sat();
        data_t exp;
        load_bias(16'sd32767);
        pixel_in = 16'sd1;
        out_en   = 1'b1;
        tick();
        exp = 16'sd32767;
        n_cmp++;
        if (pixel_out !== exp) begin
            n_bad++;
            $display("FAIL pos_sat_max_bias: got %0d expected %0d", pixel_out, exp);
        end
        pixel_in = -16'sd1;
        tick();
        exp = 16'sd32766;
        n_cmp++;
        if (pixel_out !== exp) begin
            n_bad++;
            $display("FAIL pos_no_sat: got %0d expected %0d", pixel_out, exp);
        end
        load_bias(16'sd100);
        pixel_in = 16'sd32700;
        out_en   = 1'b1;
        tick();
        exp = 16'sd32767;
        n_cmp++;
        if (pixel_out !== exp) begin
            n_bad++;
            $display("FAIL pos_sat_sum: got %0d expected %0d", pixel_out, exp);
        end
        out_en = 1'b0;
    endtask

    task automatic test_neg_sat();
        data_t exp;
        load_bias(-16'sd5);
        pixel_in = data_t'(-32768);
        out_en   = 1'b1;
        tick();
        exp = data_t'(-32768);
        n_cmp++;
        if (pixel_out !== exp) begin
            n_bad++;
            $display("FAIL neg_sat: got %0d expected %0d", pixel_out, exp);
        end
        pixel_in = 16'sd3;
        tick();
        exp = -16'sd2;
        n_cmp++;
        if (pixel_out !== exp) begin
            n_bad++;
            $display("FAIL neg_sign: got %0d expected %0d", pixel_out, exp);
        end
        pixel_in = -16'sd32760;
        tick();
        exp = -16'sd32765;
        n_cmp++;
        if (pixel_out !== exp) begin
            n_bad++;
            $display("FAIL neg_near_min: got %0d expected %0d", pixel_out, exp);
        end
        out_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        data_t exp;
        load_bias(16'sd10);
        pixel_in = 16'sd1;
        out_en   = 1'b1;
        tick();
        exp = 16'sd11;
        n_cmp++;
        if (pixel_out !== exp) begin
            n_bad++;
            $display("FAIL mid_before_reset: got %0d expected %0d", pixel_out, exp);
        end
        #2 xrst = 1'b1;
        #1;
        exp = '0;
        n_cmp++;
        if (pixel_out !== exp) begin
            n_bad++;
            $display("FAIL mid_async_clear: got %0d expected %0d", pixel_out, exp);
        end
        #1 xrst = 1'b0;
        pixel_in = 16'sd4;
        out_en   = 1'b1;
        tick();
        exp = 16'sd4;
        n_cmp++;
        if (pixel_out !== exp) begin
            n_bad++;
            $display("FAIL mid_bias_cleared: got %0d expected %0d", pixel_out, exp);
        end
        out_en = 1'b0;
    endtask

    initial begin
        xrst      = 1'b1;
        breg_we   = 1'b0;
        out_en    = 1'b0;
        read_bias = '0;
        pixel_in  = '0;
        test_reset();
        test_load_stream();
        test_collision();
        test_pos_sat();
        test_neg_sat();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
